// File: rtl/sha2_round_core.sv
// sha2_round_core -- iterative SHA-256 / SHA-512 compression round engine.
//
// One round is applied per clock while in RUN. The round constant and the
// schedule word for the current round are supplied by the caller on kt_i and
// wt_i in the same cycle that round_o shows that round index.
//
// Configuration macro: SHA2_FEEDFWD_EN
//   defined   : digest_o = captured hash_i + final a..h (word-wise, mod 2^WORD_W)
//   undefined : digest_o = raw final a..h; no feed-forward register exists
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   rst       in   synchronous active-high reset
//   start_i   in   request to compress one block
//   hash_i    in   8*WORD_W chaining value H0..H7, H0 in the MSBs
//   kt_i      in   WORD_W round constant for round round_o
//   wt_i      in   WORD_W schedule word for round round_o
//   round_o   out  7-bit round index, 0 outside RUN
//   ready_o   out  high only while idle
//   done_o    out  one-cycle pulse in the cycle digest_o takes a new value
//   digest_o  out  8*WORD_W result of the last completed block, H0 in the MSBs
//   state_o   out  FSM state for observation (IDLE=0, RUN=1, FIN=2)
//
// Handshake: start_i/ready_o form a valid/ready pair; a block is accepted at
// a rising edge where both are high. start_i while ready_o is low is dropped,
// never queued, and has no effect on a block in progress.
module sha2_round_core #(
  parameter int WORD_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [8*WORD_W-1:0]   hash_i,
  input  logic [WORD_W-1:0]     kt_i,
  input  logic [WORD_W-1:0]     wt_i,
  output logic [6:0]            round_o,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [8*WORD_W-1:0]   digest_o,
  output logic [1:0]            state_o
);

  localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

  // Big-sigma rotation amounts for the two supported word widths.
  localparam int S0_A = (WORD_W == 64) ? 28 : 2;
  localparam int S0_B = (WORD_W == 64) ? 34 : 13;
  localparam int S0_C = (WORD_W == 64) ? 39 : 22;
  localparam int S1_A = (WORD_W == 64) ? 14 : 6;
  localparam int S1_B = (WORD_W == 64) ? 18 : 11;
  localparam int S1_C = (WORD_W == 64) ? 41 : 25;

  if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
    $error("sha2_round_core: WORD_W must be 32 or 64");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [6:0]          round_q;
  logic [WORD_W-1:0]   a, b, c, d, e, f, g, h;
  logic [8*WORD_W-1:0] digest_q;
  logic [WORD_W-1:0]   t1, t2;
  logic [8*WORD_W-1:0] round_next;
  logic [8*WORD_W-1:0] digest_next;

`ifdef SHA2_FEEDFWD_EN
  logic [8*WORD_W-1:0] ff_q;
`endif

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // One compression round on the current working variables.
  always_comb begin
    t1 = h
       + (rotr(e, S1_A) ^ rotr(e, S1_B) ^ rotr(e, S1_C))
       + ((e & f) ^ (~e & g))
       + kt_i
       + wt_i;
    t2 = (rotr(a, S0_A) ^ rotr(a, S0_B) ^ rotr(a, S0_C))
       + ((a & b) ^ (a & c) ^ (b & c));
    round_next = {t1 + t2, a, b, c, d + t1, e, f, g};
  end

  // The digest is captured at the edge that retires the last round, so it is
  // already visible during FIN, the same cycle done_o is high.
  always_comb begin
    digest_next = round_next;
`ifdef SHA2_FEEDFWD_EN
    for (int i = 0; i < 8; i++) begin
      digest_next[i*WORD_W +: WORD_W] = round_next[i*WORD_W +: WORD_W] + ff_q[i*WORD_W +: WORD_W];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (round_q == LAST_ROUND) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      round_q  <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      digest_q <= '0;
`ifdef SHA2_FEEDFWD_EN
      ff_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            {a, b, c, d, e, f, g, h} <= hash_i;
            round_q <= '0;
`ifdef SHA2_FEEDFWD_EN
            ff_q    <= hash_i;
`endif
          end
        end
        RUN: begin
          {a, b, c, d, e, f, g, h} <= round_next;
          // Counter returns to 0 on the last round instead of wrapping past it.
          if (round_q == LAST_ROUND) begin
            round_q  <= '0;
            digest_q <= digest_next;
          end else begin
            round_q  <= round_q + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign round_o  = round_q;
  assign ready_o  = (state_q == IDLE);
  assign done_o   = (state_q == FIN);
  assign digest_o = digest_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_sha2_round_core.sv
// tb_sha2_round_core -- self-checking bench for sha2_round_core.
// Drives a 32-bit and a 64-bit instance; expected digests come from known
// SHA-256/SHA-512 answers and from a plain array-based SHA-256 model.
module tb_sha2_round_core;

`ifdef SHA2_FEEDFWD_EN
  localparam bit FF = 1'b1;
`else
  localparam bit FF = 1'b0;
`endif

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [255:0] ABC256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY256 =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};

  // ---------------- clock / reset / DUTs ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start32, ready32, done32;
  logic [255:0] hash32, digest32;
  logic [31:0]  kt32, wt32;
  logic [6:0]   round32;
  logic [1:0]   state32;

  logic         start64, ready64, done64;
  logic [511:0] hash64, digest64;
  logic [63:0]  kt64, wt64;
  logic [6:0]   round64;
  logic [1:0]   state64;

  sha2_round_core #(.WORD_W(32)) u_dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .hash_i(hash32), .kt_i(kt32), .wt_i(wt32),
    .round_o(round32), .ready_o(ready32), .done_o(done32), .digest_o(digest32), .state_o(state32));

  sha2_round_core #(.WORD_W(64)) u_dut64 (
    .clk(clk), .rst(rst), .start_i(start64), .hash_i(hash64), .kt_i(kt64), .wt_i(wt64),
    .round_o(round64), .ready_o(ready64), .done_o(done64), .digest_o(digest64), .state_o(state64));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] sched [80];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Message schedule expansion from the 16 words already in sched[0..15].
  function automatic void expand(input bit is64);
    for (int t = 16; t < 80; t++) begin
      if (is64) begin
        sched[t] = (ror64(sched[t-2], 19) ^ ror64(sched[t-2], 61) ^ (sched[t-2] >> 6))
                 + sched[t-7]
                 + (ror64(sched[t-15], 1) ^ ror64(sched[t-15], 8) ^ (sched[t-15] >> 7))
                 + sched[t-16];
      end else begin
        logic [31:0] w2, w15;
        w2  = sched[t-2][31:0];
        w15 = sched[t-15][31:0];
        sched[t] = {32'b0, (ror32(w2, 17) ^ ror32(w2, 19) ^ (w2 >> 10))
                         + sched[t-7][31:0]
                         + (ror32(w15, 7) ^ ror32(w15, 18) ^ (w15 >> 3))
                         + sched[t-16][31:0]};
      end
    end
  endfunction

  // SHA-256 compression without feed-forward: returns final a..h.
  function automatic logic [255:0] model_raw32(input logic [255:0] iv);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    for (int i = 0; i < 8; i++) v[i] = iv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror32(v[4], 6) ^ ror32(v[4], 11) ^ ror32(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K256[t] + sched[t][31:0];
      t2 = (ror32(v[0], 2) ^ ror32(v[0], 13) ^ ror32(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    return {v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]};
  endfunction

  function automatic logic [511:0] wordwise(input logic [511:0] x, input logic [511:0] y,
                                            input bit is64, input bit sub);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (is64) r[i*64 +: 64] = sub ? x[i*64 +: 64] - y[i*64 +: 64] : x[i*64 +: 64] + y[i*64 +: 64];
      else      r[i*32 +: 32] = sub ? x[i*32 +: 32] - y[i*32 +: 32] : x[i*32 +: 32] + y[i*32 +: 32];
    end
    return r;
  endfunction

  // Known full digest -> what the core must show for the active build.
  function automatic logic [511:0] exp_from_kat(input logic [511:0] kat, input logic [511:0] iv, input bit is64);
    return FF ? kat : wordwise(kat, iv, is64, 1'b1);
  endfunction

  function automatic logic [511:0] exp_from_raw(input logic [511:0] raw, input logic [511:0] iv);
    return FF ? wordwise(raw, iv, 1'b0, 1'b0) : raw;
  endfunction

  function automatic logic [511:0] get_dig(input bit is64);
    return is64 ? digest64 : {256'b0, digest32};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_round(input bit is64, input int r);
    if (is64) begin kt64 = K512[r]; wt64 = sched[r]; end
    else begin kt32 = K256[r]; wt32 = sched[r][31:0]; end
  endtask

  task automatic set_start(input bit is64, input logic s, input logic [511:0] hv);
    if (is64) begin start64 = s; hash64 = hv; end
    else begin start32 = s; hash32 = hv[255:0]; end
  endtask

  // Runs one block from IDLE; called at a negedge, returns at a negedge in IDLE.
  task automatic run_block(input bit is64, input logic [511:0] hv, input logic [511:0] exp,
                           input bit noise, input string tag);
    int n;
    logic [511:0] prev;
    bit rnd_ok, busy_ok, hold_ok;
    n = is64 ? 80 : 64;
    rnd_ok = 1; busy_ok = 1; hold_ok = 1;
    prev = get_dig(is64);
    check({tag, " ready before"}, is64 ? ready64 : ready32, 1);
    set_start(is64, 1'b1, hv);
    @(negedge clk);
    for (int r = 0; r < n; r++) begin
      if ((is64 ? round64 : round32) !== 7'(r)) rnd_ok = 0;
      if ((is64 ? (ready64 | done64) : (ready32 | done32)) !== 1'b0) busy_ok = 0;
      if (get_dig(is64) !== prev) hold_ok = 0;
      drive_round(is64, r);
      // Stray starts and a changing hash_i during RUN must be ignored.
      if (noise) set_start(is64, 1'($urandom_range(0, 1)), {16{$urandom}});
      else       set_start(is64, 1'b0, hv);
      @(negedge clk);
    end
    set_start(is64, 1'b0, hv);
    check({tag, " round sequence"}, rnd_ok, 1);
    check({tag, " busy during run"}, busy_ok, 1);
    check({tag, " digest hold in run"}, hold_ok, 1);
    check({tag, " done in fin"}, is64 ? done64 : done32, 1);
    check({tag, " ready in fin"}, is64 ? ready64 : ready32, 0);
    check({tag, " round in fin"}, is64 ? round64 : round32, 0);
    check({tag, " digest"}, get_dig(is64), exp);
    @(negedge clk);
    check({tag, " ready after"}, is64 ? ready64 : ready32, 1);
    check({tag, " done after"}, is64 ? done64 : done32, 0);
    check({tag, " digest held"}, get_dig(is64), exp);
  endtask

  task automatic load_abc(input bit is64);
    for (int i = 0; i < 80; i++) sched[i] = '0;
    sched[0]  = is64 ? 64'h6162638000000000 : 64'h0000000061626380;
    sched[15] = 64'h18;
    expand(is64);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [511:0] exp_abc32, exp_empty32, exp_abc64, exp_rand, iv_rand;
    bit idle_ok, seq_ok, gap_ok, dig_ok;
    int ph, last_done, n_done;

    rst = 1'b1;
    start32 = 0; hash32 = '0; kt32 = '0; wt32 = '0;
    start64 = 0; hash64 = '0; kt64 = '0; wt64 = '0;
    exp_abc32   = exp_from_kat({256'b0, ABC256}, {256'b0, IV256}, 1'b0);
    exp_empty32 = exp_from_kat({256'b0, EMPTY256}, {256'b0, IV256}, 1'b0);
    exp_abc64   = exp_from_kat(ABC512, IV512, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst ready32", ready32, 1);
    check("rst done32", done32, 0);
    check("rst round32", round32, 0);
    check("rst digest32", digest32, 0);
    check("rst ready64", ready64, 1);
    check("rst digest64", digest64, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle ready32", ready32, 1);

    // Known answers
    load_abc(1'b0);
    run_block(1'b0, {256'b0, IV256}, exp_abc32, 1'b0, "abc256");
    for (int i = 0; i < 80; i++) sched[i] = '0;
    sched[0] = 64'h80000000;
    expand(1'b0);
    run_block(1'b0, {256'b0, IV256}, exp_empty32, 1'b1, "empty256");
    load_abc(1'b1);
    run_block(1'b1, IV512, exp_abc64, 1'b0, "abc512");

    // Random blocks against the model
    for (int k = 0; k < 3; k++) begin
      iv_rand = '0;
      for (int i = 0; i < 8; i++) iv_rand[i*32 +: 32] = $urandom;
      for (int i = 0; i < 80; i++) sched[i] = '0;
      for (int i = 0; i < 16; i++) sched[i] = {32'b0, $urandom};
      expand(1'b0);
      exp_rand = exp_from_raw({256'b0, model_raw32(iv_rand[255:0])}, iv_rand);
      run_block(1'b0, iv_rand, exp_rand, 1'b1, $sformatf("rand256_%0d", k));
    end

    // Reset at round 30 aborts the block; rst wins over start_i
    load_abc(1'b0);
    set_start(1'b0, 1'b1, {256'b0, IV256});
    @(negedge clk);
    set_start(1'b0, 1'b0, {256'b0, IV256});
    for (int r = 0; r < 30; r++) begin
      drive_round(1'b0, r);
      @(negedge clk);
    end
    check("abort round30", round32, 30);
    rst = 1'b1;
    start32 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start32 = 1'b0;
    check("abort ready", ready32, 1);
    check("abort done", done32, 0);
    check("abort round", round32, 0);
    check("abort digest", digest32, 0);
    idle_ok = 1;
    for (int i = 0; i < 70; i++) begin
      if (done32 !== 1'b0 || digest32 !== '0 || ready32 !== 1'b1) idle_ok = 0;
      @(negedge clk);
    end
    check("abort no done", idle_ok, 1);
    run_block(1'b0, {256'b0, IV256}, exp_abc32, 1'b0, "abc256 after abort");

    // start_i held high for 200 cycles: one block every 66 cycles
    seq_ok = 1; gap_ok = 1; dig_ok = 1;
    ph = 0; last_done = -1; n_done = 0;
    hash32 = IV256;
    for (int t = 0; t < 265; t++) begin
      start32 = (t < 200);
      if (ready32 !== (ph == 0)) seq_ok = 0;
      if (done32 !== (ph == 65)) seq_ok = 0;
      if (round32 !== ((ph >= 1 && ph <= 64) ? 7'(ph - 1) : 7'd0)) seq_ok = 0;
      if (done32 === 1'b1) begin
        if (last_done >= 0 && t - last_done != 66) gap_ok = 0;
        if (digest32 !== exp_abc32[255:0]) dig_ok = 0;
        last_done = t;
        n_done++;
      end
      if (ph >= 1 && ph <= 64) drive_round(1'b0, ph - 1);
      @(negedge clk);
      ph = (ph == 65) ? 0 : ph + 1;
    end
    start32 = 1'b0;
    check("b2b sequence", seq_ok, 1);
    check("b2b spacing", gap_ok, 1);
    check("b2b digest", dig_ok, 1);
    check("b2b pulses", n_done, 4);
    check("b2b idle", ready32, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
